// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Optional read support is compiled in with I2C_SLAVE_READ_EN.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_DATA   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_DATA   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  // Bits clocked per byte before the acknowledge clock.
  localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection for one I2C line.
// Level and edges come from the two oldest stages so they stay aligned.
`timescale 1ns/1ps
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw line in; preset high to match an idle pulled-up bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
  assign o_fall  = ~r_sync[SYNC_STAGES-2] &  r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, write bytes with ACK.
// Define I2C_SLAVE_READ_EN to also serve master reads from tx_data.
`timescale 1ns/1ps
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

`ifdef I2C_SLAVE_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  i2c_state_t  r_state;
  logic [7:0]  r_shift;
  logic [3:0]  r_cnt;
  logic        r_sda_low;

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_ok;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .i_in(scl),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .i_in(sda),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start   = w_sda_fall & w_scl_lvl;
  assign w_stop    = w_sda_rise & w_scl_lvl;
  assign w_addr_ok = (r_shift[7:1] == SLAVE_ADDR) &&
                     ((r_shift[0] == I2C_RW_WRITE) || READ_EN);

  // Open drain: only ever pull low or release.
  assign sda = r_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_READ_EN
  logic       r_tx_req;
  logic       r_tx_req_d;
  logic [7:0] r_tx_hold;

  assign tx_req = r_tx_req;

  // Capture the requested byte one clock after the request strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_req_d <= 1'b0;
      r_tx_hold  <= '0;
    end else begin
      r_tx_req_d <= r_tx_req;
      if (r_tx_req_d) begin
        r_tx_hold <= tx_data;
      end
    end
  end
`else
  logic w_unused_tx;
  assign w_unused_tx = ^tx_data;
  assign tx_req      = 1'b0;
`endif

  // Protocol FSM; bus conditions override any same-cycle bit event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_sda_low <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      r_tx_req  <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      start_det <= w_start;
      stop_det  <= w_stop;
`ifdef I2C_SLAVE_READ_EN
      r_tx_req  <= 1'b0;
`endif
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_sda_low <= 1'b0;
        busy      <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_cnt     <= '0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda_lvl};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && (r_cnt == I2C_BYTE_BITS)) begin
              r_cnt <= '0;
              if (w_addr_ok) begin
                r_sda_low <= 1'b1;
                busy      <= 1'b1;
                r_state   <= ST_ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
                r_tx_req  <= (r_shift[0] == I2C_RW_READ);
`endif
              end else begin
                busy    <= 1'b0;
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            // R/W bit stays in r_shift[0] because the ACK clock never shifts.
            if (w_scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
              if (r_shift[0] == I2C_RW_READ) begin
                r_shift   <= r_tx_hold;
                r_sda_low <= ~r_tx_hold[7];
                r_state   <= ST_TX_DATA;
              end else begin
                r_sda_low <= 1'b0;
                r_state   <= ST_RX_DATA;
              end
`else
              r_sda_low <= 1'b0;
              r_state   <= ST_RX_DATA;
`endif
            end
          end
          ST_RX_DATA: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda_lvl};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && (r_cnt == I2C_BYTE_BITS)) begin
              rx_data   <= r_shift;
              rx_valid  <= 1'b1;
              r_sda_low <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_RX_ACK;
            end
          end
          ST_RX_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_state   <= ST_RX_DATA;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          ST_TX_DATA: begin
            // Bit 7 is already on the line at entry; later falls present the rest.
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_cnt == I2C_BYTE_BITS) begin
                r_sda_low <= 1'b0;
                r_cnt     <= '0;
                r_tx_req  <= 1'b1;
                r_state   <= ST_TX_ACK;
              end else if (r_cnt != 4'd0) begin
                r_sda_low <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end
          end
          ST_TX_ACK: begin
            if (w_scl_rise && (w_sda_lvl == I2C_NACK)) begin
              busy    <= 1'b0;
              r_state <= ST_WAIT_STOP;
            end else if (w_scl_fall) begin
              r_shift   <= r_tx_hold;
              r_sda_low <= ~r_tx_hold[7];
              r_state   <= ST_TX_DATA;
            end
          end
`endif
          default: begin
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master tasks plus a transaction model.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 5;  // clocks per quarter of an SCL bit

`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl_low = 1'b0;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h3C;
  logic       scl_line;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, start_det, stop_det;

  assign scl_line = ~m_scl_low;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl_line), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  int checks = 0, errors = 0;
  int n_start = 0, n_stop = 0, n_rx = 0, n_txreq = 0;
  int exp_start = 0, exp_stop = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_last = '0;
  logic [7:0] e_byte;
  bit m_addr = 0;
  bit chk_sda = 0, exp_sda = 1;
  bit chk_busy = 0, exp_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every clock while the bus is active.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_sda)  check("sda_line", 32'(sda), 32'(exp_sda));
      if (chk_busy) check("busy", 32'(busy), 32'(exp_busy));
      if (rx_valid) begin
        n_rx++;
        rx_last = rx_data;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_valid: unexpected strobe rx_data=%0h, required no strobe", rx_data);
        end else begin
          e_byte = exp_q.pop_front();
          if (rx_data !== e_byte) begin
            errors++;
            $display("FAIL rx_data: got %0h, required %0h", rx_data, e_byte);
          end
        end
      end
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (tx_req)    n_txreq++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl_low = 1'b0; wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl_low = 1'b1; wait_clk(Q);
    exp_start++;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl_low = 1'b0; wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2 * Q);
    exp_stop++;
    m_addr = 1'b0;
  endtask

  // One SCL clock: master puts drv on SDA (1 = release), model says what the line must read.
  task automatic clk_bit(input bit drv, input bit exp_line, input bit bchk, output bit line);
    m_sda_low = ~drv; wait_clk(Q);
    m_scl_low = 1'b0;
    exp_sda = exp_line; exp_busy = m_addr; chk_busy = bchk; chk_sda = 1'b1;
    wait_clk(Q);
    line = sda;
    wait_clk(Q);
    chk_sda = 1'b0; chk_busy = 1'b0;
    m_scl_low = 1'b1; wait_clk(Q);
  endtask

  // Master writes one byte; returns the acknowledge level seen on the 9th clock.
  task automatic send_byte(input logic [7:0] b, input bit is_addr, output bit ack);
    bit line;
    if (is_addr) m_addr = (b[7:1] == 7'h50) && (b[0] == 1'b0 || READ_EN);
    else if (m_addr) exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], b[i], !is_addr, line);
    clk_bit(1'b1, ~m_addr, 1'b1, ack);
  endtask

  task automatic tally(input string tname);
    check({tname, "_rx_pending"}, exp_q.size(), 0);
    check({tname, "_start_count"}, n_start, exp_start);
    check({tname, "_stop_count"}, n_stop, exp_stop);
    check({tname, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit ack, line;
    int rx0, tq0;
    logic [7:0] got;

    // Reset values
    wait_clk(5);
    @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start_det", 32'(start_det), 0);
    check("rst_stop_det", 32'(stop_det), 0);
    check("rst_tx_req", 32'(tx_req), 0);
    check("rst_sda", 32'(sda), 1);
    rst = 1'b0;
    wait_clk(2 * Q);

    // 1: addressed write of one byte
    rx0 = n_rx;
    bus_start();
    send_byte(8'hA0, 1, ack); check("t1_addr_ack", 32'(ack), 0);
    send_byte(8'hA5, 0, ack); check("t1_data_ack", 32'(ack), 0);
    bus_stop();
    check("t1_rx_count", n_rx - rx0, 1);
    check("t1_rx_data", 32'(rx_last), 32'hA5);
    tally("t1");

    // 2: wrong address is ignored
    rx0 = n_rx;
    bus_start();
    send_byte(8'hA2, 1, ack); check("t2_addr_nack", 32'(ack), 1);
    send_byte(8'hFF, 0, ack); check("t2_data_nack", 32'(ack), 1);
    bus_stop();
    check("t2_rx_count", n_rx - rx0, 0);
    tally("t2");

    // 3: multi-byte write
    rx0 = n_rx;
    bus_start();
    send_byte(8'hA0, 1, ack);
    send_byte(8'h11, 0, ack); check("t3_ack1", 32'(ack), 0);
    send_byte(8'h22, 0, ack); check("t3_ack2", 32'(ack), 0);
    send_byte(8'h33, 0, ack); check("t3_ack3", 32'(ack), 0);
    bus_stop();
    check("t3_rx_count", n_rx - rx0, 3);
    check("t3_rx_last", 32'(rx_last), 32'h33);
    tally("t3");

    // 4: repeated START abandons a partial byte
    rx0 = n_rx;
    bus_start();
    send_byte(8'hA0, 1, ack);
    clk_bit(1'b1, 1'b1, 1'b1, line);
    clk_bit(1'b0, 1'b0, 1'b1, line);
    clk_bit(1'b1, 1'b1, 1'b1, line);
    clk_bit(1'b1, 1'b1, 1'b1, line);
    bus_start();
    send_byte(8'hA0, 1, ack); check("t4_readdr_ack", 32'(ack), 0);
    send_byte(8'h7E, 0, ack);
    bus_stop();
    check("t4_rx_count", n_rx - rx0, 1);
    check("t4_rx_data", 32'(rx_last), 32'h7E);
    tally("t4");

    // 5: read request
    tq0 = n_txreq;
    bus_start();
    send_byte(8'hA1, 1, ack);
`ifdef I2C_SLAVE_READ_EN
    check("t5_addr_ack", 32'(ack), 0);
    check("t5_txreq_first", n_txreq - tq0, 1);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, tx_data[i], 1'b1, line);
      got[i] = line;
    end
    check("t5_read_byte", 32'(got), 32'h3C);
    clk_bit(1'b1, 1'b1, 1'b0, line);
    m_addr = 1'b0;
    check("t5_txreq_total", n_txreq - tq0, 2);
    clk_bit(1'b1, 1'b1, 1'b1, line);
`else
    check("t5_addr_nack", 32'(ack), 1);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b1, 1'b1, line);
      got[i] = line;
    end
    check("t5_released", 32'(got), 32'hFF);
    check("t5_txreq_none", n_txreq - tq0, 0);
`endif
    bus_stop();
    tally("t5");

    // 6: reset while the address ACK is driven
    rx0 = n_rx;
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      e_byte = 8'hA0;
      clk_bit(e_byte[i], e_byte[i], 1'b0, line);
    end
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl_low = 1'b0; wait_clk(Q);
    @(negedge clk);
    check("t6_ack_before_rst", 32'(sda), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_sda_released", 32'(sda), 1);
    check("t6_busy_cleared", 32'(busy), 0);
    check("t6_rx_valid", 32'(rx_valid), 0);
    m_addr = 1'b0;
    wait_clk(Q);
    m_scl_low = 1'b1; wait_clk(Q);
    clk_bit(1'b0, 1'b0, 1'b1, line);
    clk_bit(1'b1, 1'b1, 1'b1, line);
    clk_bit(1'b0, 1'b0, 1'b1, line);
    bus_stop();
    check("t6_no_partial", n_rx - rx0, 0);
    bus_start();
    send_byte(8'hA0, 1, ack); check("t6_addr_ack", 32'(ack), 0);
    send_byte(8'h5A, 0, ack); check("t6_data_ack", 32'(ack), 0);
    bus_stop();
    check("t6_rx_data", 32'(rx_last), 32'h5A);
    tally("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
